usb_data_tx: RTL and testbench

// - Transmit path for USB DATA packets, the sender-side counterpart of the

---
 rtl/usb_pkg.sv | 31 +++
 rtl/usb_crc16_gen.sv | 22 ++
 rtl/usb_data_tx.sv | 161 ++++++++++++++++
 tb/tb_usb_data_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB constants and types used by the transmit/receive paths.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  localparam logic [7:0]  SYNC_BYTE     = 8'h80;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam int          STUFF_LIMIT   = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_SE0  = 3'd5,
    ST_EOPJ = 3'd6
  } tx_state_t;

endpackage

// File: rtl/usb_crc16_gen.sv
// Serial CRC16 generator (MSB-first register, bits fed in wire order).
module usb_crc16_gen
  import usb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_bit,
  input  logic        shift_en,
  input  logic        clear,
  output logic [15:0] crc
);

  logic fb;
  assign fb = in_bit ^ crc[15];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      crc <= CRC16_INIT;
    else if (clear)    crc <= CRC16_INIT;
    else if (shift_en) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/usb_data_tx.sv
// USB DATA packet transmitter: SYNC/PID/payload/CRC16, bit stuffing, NRZI, EOP.
module usb_data_tx
  import usb_pkg::*;
#(
  parameter int DATA_BITS = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [3:0]           pid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 DP_out,
  output logic                 DM_out,
  output logic                 tx_en
);

  localparam int CNT_W = ($clog2(DATA_BITS) > 5) ? $clog2(DATA_BITS) : 5;

  tx_state_t            state, state_nx;
  logic [CNT_W-1:0]     bit_cnt, cnt_nx;
  logic [2:0]           ones_cnt, ones_nx;
  logic                 level, level_nx;
  logic [7:0]           pid_q;
  logic [DATA_BITS-1:0] data_q;
  logic [15:0]          crc;

  logic accept, stuff, raw_bit, line_bit, crc_shift;
  logic dp_nx, dm_nx, en_nx;

  assign accept = start && !busy && (state == ST_IDLE);
  assign stuff  = (state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC}) &&
                  (ones_cnt == 3'(STUFF_LIMIT));

  always_comb begin
    raw_bit = 1'b0;
    case (state)
      ST_SYNC: raw_bit = SYNC_BYTE[bit_cnt[2:0]];
      ST_PID:  raw_bit = pid_q[bit_cnt[2:0]];
      ST_DATA: raw_bit = data_q[0];
      ST_CRC:  raw_bit = ~crc[4'd15 - bit_cnt[3:0]];
      default: raw_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = bit_cnt;
    ones_nx   = ones_cnt;
    level_nx  = level;
    line_bit  = 1'b0;
    crc_shift = 1'b0;
    dp_nx     = 1'b1;
    dm_nx     = 1'b0;
    en_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SYNC;
          cnt_nx   = '0;
          ones_nx  = '0;
          level_nx = 1'b1;
        end
      end
      ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
        en_nx = 1'b1;
        if (stuff) begin
          line_bit = 1'b0;
          ones_nx  = '0;
          // bit_cnt==16 marks a stuff owed after the last CRC bit
          if (state == ST_CRC && bit_cnt == CNT_W'(16)) begin
            state_nx = ST_SE0;
            cnt_nx   = '0;
          end
        end else begin
          line_bit  = raw_bit;
          ones_nx   = raw_bit ? ones_cnt + 3'd1 : 3'd0;
          cnt_nx    = bit_cnt + 1'b1;
          crc_shift = (state == ST_DATA);
          case (state)
            ST_SYNC: if (bit_cnt == CNT_W'(7)) begin state_nx = ST_PID; cnt_nx = '0; end
            ST_PID:  if (bit_cnt == CNT_W'(7)) begin state_nx = ST_DATA; cnt_nx = '0; end
            ST_DATA: if (bit_cnt == CNT_W'(DATA_BITS-1)) begin state_nx = ST_CRC; cnt_nx = '0; end
            default: if (bit_cnt == CNT_W'(15) && ones_nx != 3'(STUFF_LIMIT)) begin
              state_nx = ST_SE0;
              cnt_nx   = '0;
            end
          endcase
        end
        level_nx = line_bit ? level : ~level;
        dp_nx    = level_nx;
        dm_nx    = ~level_nx;
      end
      ST_SE0: begin
        en_nx  = 1'b1;
        dp_nx  = 1'b0;
        cnt_nx = bit_cnt + 1'b1;
        if (bit_cnt == CNT_W'(1)) begin
          state_nx = ST_EOPJ;
          cnt_nx   = '0;
        end
      end
      ST_EOPJ: begin
        en_nx    = 1'b1;
        level_nx = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  usb_crc16_gen u_crc (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_bit   (data_q[0]),
    .shift_en (crc_shift),
    .clear    (accept),
    .crc      (crc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      level    <= 1'b1;
      pid_q    <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= cnt_nx;
      ones_cnt <= ones_nx;
      level    <= level_nx;
      if (accept) begin
        pid_q  <= {~pid, pid};
        data_q <= data;
      end else if (crc_shift) begin
        data_q <= data_q >> 1;
      end
    end
  end

  // Outputs trail the state by one register stage; done follows the EOP J cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      DP_out <= 1'b1;
      DM_out <= 1'b0;
      tx_en  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      DP_out <= dp_nx;
      DM_out <= dm_nx;
      tx_en  <= en_nx;
      busy   <= (state != ST_IDLE);
      done   <= busy && (state == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_usb_data_tx.sv
// Bench for usb_data_tx: per-cycle wire model plus loopback decode of each packet.
module tb_usb_data_tx;

  localparam int DB = 64;
  localparam logic [4:0] IDLE_E = 5'b00010;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    pid = 4'h0;
  logic [DB-1:0] data = '0;
  logic          busy, done, DP_out, DM_out, tx_en;

  usb_data_tx #(.DATA_BITS(DB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .pid     (pid),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .DP_out  (DP_out),
    .DM_out  (DM_out),
    .tx_en   (tx_en)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] expq[$];   // {busy, done, tx_en, DP, DM} per cycle
  logic [1:0] cap[$];    // {DP, DM} while tx_en
  logic       cap_on = 1'b0;

  always @(negedge clock) begin
    logic [4:0] e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {busy, done, tx_en, DP_out, DM_out};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL wire: got b/d/en/dp/dm=%b want %b at %0t", a, e, $time);
      end
    end
    if (cap_on && tx_en) cap.push_back({DP_out, DM_out});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reflected USB CRC16 over the payload; returned value is the field, sent LSB first.
  function automatic logic [15:0] crc_field(input logic [DB-1:0] d);
    logic [15:0] r = 16'hFFFF;
    for (int i = 0; i < DB; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return ~r;
  endfunction

  task automatic push_packet(input logic [3:0] p, input logic [DB-1:0] d, input int lead);
    bit raw[$];
    bit line[$];
    int ones;
    logic lvl;
    logic [15:0] c;
    for (int i = 0; i < lead; i++) expq.push_back(IDLE_E);
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int i = 0; i < 4; i++) raw.push_back(p[i]);
    for (int i = 0; i < 4; i++) raw.push_back(~p[i]);
    for (int i = 0; i < DB; i++) raw.push_back(d[i]);
    c = crc_field(d);
    for (int i = 0; i < 16; i++) raw.push_back(c[i]);
    ones = 0;
    foreach (raw[i]) begin
      line.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (line[i]) begin
      if (!line[i]) lvl = ~lvl;
      expq.push_back({3'b101, lvl, ~lvl});
    end
    expq.push_back(5'b10100);
    expq.push_back(5'b10100);
    expq.push_back(5'b10110);
    expq.push_back(5'b01010);
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while (expq.size() > 0 && k < max_cyc) begin
      @(posedge clock);
      k++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
    #1;
  endtask

  // Receive chain on the captured wire: NRZI decode, unstuff, field and residue checks.
  task automatic decode(input logic [3:0] p, input logic [DB-1:0] d,
                        output int pay_stuff, output int tot_stuff,
                        output int first_stuff, output logic [7:0] pb);
    bit raw[$];
    int n, ones, bad;
    logic [1:0] prev;
    logic [7:0] sb;
    logic [DB-1:0] dd;
    logic [15:0] r;
    bit b;
    pay_stuff = 0; tot_stuff = 0; first_stuff = -1; pb = 8'h00;
    n = cap.size();
    if (n < 3) begin
      chk("cap_len", 64'(n), 64'd3);
      return;
    end
    chk("eop", {cap[n-3], cap[n-2], cap[n-1]}, 64'b00_00_10);
    prev = 2'b10; ones = 0; bad = 0;
    for (int i = 0; i < n - 3; i++) begin
      if (cap[i] != 2'b10 && cap[i] != 2'b01) bad++;
      b = (cap[i] == prev);
      prev = cap[i];
      if (ones == 6) begin
        if (b) bad++;
        tot_stuff++;
        if (first_stuff < 0) first_stuff = raw.size();
        if (raw.size() >= 17 && raw.size() <= 16 + DB) pay_stuff++;
        ones = 0;
      end else begin
        raw.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
    chk("line_symbols", 64'(bad), 64'd0);
    chk("raw_len", 64'(raw.size()), 64'(32 + DB));
    chk("tx_len", 64'(n), 64'(35 + DB + tot_stuff));
    if (raw.size() != 32 + DB) return;
    for (int i = 0; i < 8; i++) sb[i] = raw[i];
    for (int i = 0; i < 8; i++) pb[i] = raw[8 + i];
    for (int i = 0; i < DB; i++) dd[i] = raw[16 + i];
    r = 16'hFFFF;
    for (int i = 16; i < 32 + DB; i++)
      r = (r[0] ^ raw[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    chk("sync_byte", sb, 8'h80);
    chk("pid_byte", pb, {~p, p});
    chk("payload", dd, d);
    chk("crc_residue", r, 16'hB001);
  endtask

  task automatic send(input logic [3:0] p, input logic [DB-1:0] d,
                      output int ps, output int ts, output int fs, output logic [7:0] pb);
    @(posedge clock); #1;
    pid = p; data = d; start = 1'b1;
    cap.delete(); cap_on = 1'b1;
    push_packet(p, d, 2);
    @(posedge clock); #1;
    start = 1'b0;
    drain(400);
    cap_on = 1'b0;
    decode(p, d, ps, ts, fs, pb);
  endtask

  initial begin
    int ps, ts, fs, k;
    logic [7:0] pb;
    logic [1:0] sync_exp[8];
    logic [DB-1:0] d1, d2;
    sync_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {busy, done, tx_en, DP_out, DM_out}, IDLE_E);
    reset_n = 1'b1;
    repeat (20) expq.push_back(IDLE_E);
    drain(40);

    send(4'b0011, 64'h0, ps, ts, fs, pb);
    for (int i = 0; i < 8; i++) chk($sformatf("sync_sym%0d", i), cap[i], sync_exp[i]);
    chk("pid_c3", pb, 8'hC3);
    chk("zero_pay_stuff", 64'(ps), 64'd0);

    send(4'b0011, {DB{1'b1}}, ps, ts, fs, pb);
    chk("ones_pay_stuff", 64'(ps), 64'd11);
    chk("ones_first_stuff", 64'(fs), 64'd20);
    chk("ones_len", 64'(cap.size()), 64'(110 + ts - ps));

    for (int i = 0; i < 20; i++)
      send((i % 2) ? 4'b1011 : 4'b0011, {$urandom, $urandom}, ps, ts, fs, pb);

    // start held across a whole packet: next packet follows done directly
    d1 = 64'h0123_4567_89AB_CDEF;
    d2 = 64'hFEDC_BA98_7654_3210;
    @(posedge clock); #1;
    pid = 4'b0011; data = d1; start = 1'b1;
    push_packet(4'b0011, d1, 2);
    k = 0;
    while (!done && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    chk("held_done_seen", 64'(done), 64'd1);
    data = d2;
    push_packet(4'b0011, d2, 1);
    @(posedge clock); #1;
    start = 1'b0;
    drain(400);

    // reset in the middle of the payload
    @(posedge clock); #1;
    pid = 4'b1011; data = 64'hA5A5_5A5A_0F0F_F0F0; start = 1'b1;
    push_packet(4'b1011, 64'hA5A5_5A5A_0F0F_F0F0, 2);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    chk("pre_reset_busy", {busy, tx_en}, 2'b11);
    reset_n = 1'b0;
    expq.delete();
    #1;
    chk("reset_async", {busy, done, tx_en, DP_out, DM_out}, IDLE_E);
    repeat (12) expq.push_back(IDLE_E);
    @(posedge clock); #1;
    reset_n = 1'b1;
    drain(40);

    send(4'b0011, 64'hDEAD_BEEF_CAFE_F00D, ps, ts, fs, pb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
